// File: rtl/instr_sequencer_if.sv
// Host/processor-facing signal bundle for instr_sequencer.
// The master side is the host plus the processor; the slave side is the sequencer itself.
interface instr_sequencer_if #(
    parameter int AW = 4
);
    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [15:0]   load_data;
    logic          start;
    logic [AW:0]   prog_len;
    logic          proc_done;
    logic [15:0]   instr_out;
    logic          run;
    logic          busy;
    logic          prog_done;
    logic          error;
    logic [AW-1:0] pc;
    logic [15:0]   instr_count;

    modport master (
        output load_en, load_addr, load_data, start, prog_len, proc_done,
        input  instr_out, run, busy, prog_done, error, pc, instr_count
    );

    modport slave (
        input  load_en, load_addr, load_data, start, prog_len, proc_done,
        output instr_out, run, busy, prog_done, error, pc, instr_count
    );
endinterface

// File: rtl/instr_sequencer.sv
// Issues a stored instruction program to the two-register processor one word at a time,
// handshaking on run/done, with a per-instruction timeout that latches a sticky error.
module instr_sequencer #(
    parameter int DEPTH   = 16,
    parameter int AW      = 4,
    parameter int TIMEOUT = 8
) (
    input  logic               clk,
    input  logic               reset,
    instr_sequencer_if.slave   bus
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [AW:0] LEN_MAX = (AW+1)'(DEPTH);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_FIN   = 3'd3;
    localparam logic [2:0] S_ERR   = 3'd4;

    logic [2:0]    r_state;
    logic [AW-1:0] r_pc;
    logic [AW:0]   r_len;
    logic [15:0]   r_count;
    logic [TW-1:0] r_tmo;
    logic [15:0]   r_mem [DEPTH];

    logic [AW:0]   w_len;
    logic [AW:0]   w_pc_next;
    logic [TW-1:0] w_tmo_next;
    logic          w_active;

    assign w_len      = (bus.prog_len > LEN_MAX) ? LEN_MAX : bus.prog_len;
    assign w_pc_next  = {1'b0, r_pc} + (AW+1)'(1);
    assign w_tmo_next = r_tmo + TW'(1);
    assign w_active   = (r_state == S_ISSUE) || (r_state == S_WAIT);

    // Store is deliberately left uninitialised by reset so a program survives a processor reset.
    always_ff @(posedge clk) begin
        if (!reset && r_state == S_IDLE && bus.load_en)
            r_mem[bus.load_addr] <= bus.load_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
            r_len   <= '0;
            r_count <= '0;
            r_tmo   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_pc    <= '0;
                        r_count <= '0;
                        r_len   <= w_len;
                        r_state <= (w_len == '0) ? S_FIN : S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_tmo   <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.proc_done) begin
                        r_count <= r_count + 16'd1;
                        if (w_pc_next == r_len) begin
                            r_state <= S_FIN;
                        end else begin
                            r_pc    <= w_pc_next[AW-1:0];
                            r_state <= S_ISSUE;
                        end
                    end else if (w_tmo_next == TW'(TIMEOUT)) begin
                        r_state <= S_ERR;
                    end else begin
                        r_tmo <= w_tmo_next;
                    end
                end
                S_FIN:   r_state <= S_IDLE;
                S_ERR:   r_state <= S_ERR;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Outputs decode straight from state so run follows start by exactly one edge.
    assign bus.run         = (r_state == S_ISSUE);
    assign bus.instr_out   = w_active ? r_mem[r_pc] : 16'h0000;
    assign bus.busy        = w_active;
    assign bus.prog_done   = (r_state == S_FIN);
    assign bus.error       = (r_state == S_ERR);
    assign bus.pc          = r_pc;
    assign bus.instr_count = r_count;
endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer with a small behavioural model of the two-register processor.
module tb_instr_sequencer;
    localparam int DEPTH   = 16;
    localparam int AW      = 4;
    localparam int TIMEOUT = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    instr_sequencer_if #(.AW(AW)) bus();

    instr_sequencer #(.DEPTH(DEPTH), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Processor model: op [15:13] (001 mv, 011 add, 110 mult), bit 12 = rX for mv/add,
    // rY for mult (r0 <= r0 * rY), 9-bit immediate. mv answers in 1 cycle, others in 3.
    logic        p_en;
    logic [15:0] p_ir;
    logic [1:0]  p_k;
    logic [15:0] r0, r1;
    logic        p_fire;
    logic [15:0] p_x;

    always @(posedge clk) begin
        p_fire = 1'b0;
        p_x    = p_ir;
        if (reset) begin
            bus.proc_done <= 1'b0;
            p_k           <= 2'd0;
        end else begin
            bus.proc_done <= 1'b0;
            if (bus.run && p_en) begin
                p_ir <= bus.instr_out;
                if (bus.instr_out[15:13] == 3'b001) begin
                    bus.proc_done <= 1'b1;
                    p_fire = 1'b1;
                    p_x    = bus.instr_out;
                end else begin
                    p_k <= 2'd2;
                end
            end else if (p_k != 2'd0) begin
                p_k <= p_k - 2'd1;
                if (p_k == 2'd1) begin
                    bus.proc_done <= 1'b1;
                    p_fire = 1'b1;
                end
            end
        end
        if (p_fire) begin
            case (p_x[15:13])
                3'b001: if (p_x[12]) r1 <= {7'd0, p_x[8:0]}; else r0 <= {7'd0, p_x[8:0]};
                3'b011: if (p_x[12]) r1 <= r1 + {7'd0, p_x[8:0]}; else r0 <= r0 + {7'd0, p_x[8:0]};
                3'b110: r0 <= r0 * (p_x[12] ? r1 : r0);
                default: ;
            endcase
        end
    end

    // Monitor: cumulative event counts and cycle stamps
    int cyc = 0, run_n = 0, pd_n = 0, pd_cyc = 0, done_cyc = 0;
    int run_cyc [0:255];
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.run) begin
            run_cyc[run_n & 255] <= cyc;
            run_n <= run_n + 1;
        end
        if (bus.proc_done) done_cyc <= cyc;
        if (bus.prog_done) begin
            pd_n   <= pd_n + 1;
            pd_cyc <= cyc;
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load(input logic [AW-1:0] a, input logic [15:0] d);
        bus.load_en   = 1'b1;
        bus.load_addr = a;
        bus.load_data = d;
        tick(1);
        bus.load_en   = 1'b0;
    endtask

    task automatic go(input logic [AW:0] len);
        bus.start    = 1'b1;
        bus.prog_len = len;
        tick(1);
        bus.start    = 1'b0;
    endtask

    task automatic wait_pd(input string tag, input int limit);
        int n = 0;
        while (!bus.prog_done && n < limit) begin
            tick(1);
            n++;
        end
        check(tag, {31'd0, bus.prog_done}, 32'd1);
    endtask

    task automatic wait_wait_pc(input string tag, input logic [AW-1:0] p, input int limit);
        int n = 0;
        while (!(bus.busy && !bus.run && bus.pc == p) && n < limit) begin
            tick(1);
            n++;
        end
        check(tag, {31'd0, (bus.busy && !bus.run && bus.pc == p)}, 32'd1);
    endtask

    int b, pd0;

    initial begin
        reset = 1'b1;
        bus.load_en = 1'b0; bus.load_addr = '0; bus.load_data = '0;
        bus.start = 1'b0; bus.prog_len = '0;
        p_en = 1'b1; p_ir = '0; r0 = '0; r1 = '0;
        tick(2);
        reset = 1'b0;
        check("rst_run",   {31'd0, bus.run}, 0);
        check("rst_instr", {16'd0, bus.instr_out}, 0);
        check("rst_busy",  {31'd0, bus.busy}, 0);
        check("rst_pdone", {31'd0, bus.prog_done}, 0);
        check("rst_err",   {31'd0, bus.error}, 0);
        check("rst_pc",    {28'd0, bus.pc}, 0);
        check("rst_cnt",   {16'd0, bus.instr_count}, 0);

        // mv r0,#5 ; add r0,#3
        load(0, 16'h2005);
        load(1, 16'h6003);
        b = run_n; pd0 = pd_n;
        go(2);
        check("t1_run_first", {31'd0, bus.run}, 1);
        check("t1_instr0", {16'd0, bus.instr_out}, 32'h2005);
        wait_pd("t1_finish", 40);
        check("t1_r0", {16'd0, r0}, 8);
        check("t1_cnt", {16'd0, bus.instr_count}, 2);
        tick(1);
        check("t1_runs", run_n - b, 2);
        check("t1_spacing", run_cyc[(b + 1) & 255] - run_cyc[b & 255], 2);
        check("t1_pd_once", pd_n - pd0, 1);
        check("t1_busy_off", {31'd0, bus.busy}, 0);

        // mv r0,#7 ; mv r1,#2 ; mult r0,r1
        load(0, 16'h2007);
        load(1, 16'h3002);
        load(2, 16'hD000);
        b = run_n;
        go(3);
        wait_pd("t2_finish", 60);
        check("t2_r0", {16'd0, r0}, 14);
        check("t2_r1", {16'd0, r1}, 2);
        check("t2_cnt", {16'd0, bus.instr_count}, 3);
        tick(1);
        check("t2_pd_lat", pd_cyc - done_cyc, 1);
        check("t2_runs", run_n - b, 3);

        // zero-length program
        b = run_n; pd0 = pd_n;
        go(0);
        check("t3_pd_now", {31'd0, bus.prog_done}, 1);
        check("t3_busy", {31'd0, bus.busy}, 0);
        tick(1);
        check("t3_pd_gone", {31'd0, bus.prog_done}, 0);
        check("t3_no_run", run_n - b, 0);
        check("t3_pd_once", pd_n - pd0, 1);

        // length 20 clamps to 16
        for (int i = 0; i < 16; i++) load(i[AW-1:0], 16'h2000 | 16'(i));
        b = run_n;
        go(20);
        wait_pd("t3_clamp_finish", 200);
        check("t3_clamp_cnt", {16'd0, bus.instr_count}, 16);
        check("t3_clamp_pc", {28'd0, bus.pc}, 15);
        check("t3_clamp_r0", {16'd0, r0}, 15);
        tick(1);
        check("t3_clamp_runs", run_n - b, 16);

        // timeout with done tied low
        p_en = 1'b0;
        load(0, 16'h200A);
        b = run_n;
        go(1);
        tick(8);
        check("t4_err_early", {31'd0, bus.error}, 0);
        check("t4_busy_wait", {31'd0, bus.busy}, 1);
        tick(1);
        check("t4_err_set", {31'd0, bus.error}, 1);
        check("t4_err_instr", {16'd0, bus.instr_out}, 0);
        check("t4_err_busy", {31'd0, bus.busy}, 0);
        load(0, 16'h2003);
        go(1);
        tick(2);
        check("t4_err_sticky", {31'd0, bus.error}, 1);
        check("t4_one_run", run_n - b, 1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("t4_err_clr", {31'd0, bus.error}, 0);
        p_en = 1'b1;
        go(1);
        wait_pd("t4_rerun_finish", 20);
        check("t4_load_ignored", {16'd0, r0}, 32'h0A);
        tick(1);

        // reset during WAIT of instruction 2 of 3
        load(0, 16'h2001);
        load(1, 16'h6002);
        load(2, 16'h6004);
        go(3);
        wait_wait_pc("t5_reach_wait", 1, 20);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("t5_pc", {28'd0, bus.pc}, 0);
        check("t5_busy", {31'd0, bus.busy}, 0);
        check("t5_cnt", {16'd0, bus.instr_count}, 0);
        go(3);
        check("t5_rerun_instr0", {16'd0, bus.instr_out}, 32'h2001);
        wait_pd("t5_rerun_finish", 40);
        check("t5_r0", {16'd0, r0}, 7);
        check("t5_cnt3", {16'd0, bus.instr_count}, 3);
        tick(1);

        // load and start while busy are both ignored
        go(3);
        wait_wait_pc("t6_reach_wait", 1, 20);
        bus.load_en = 1'b1; bus.load_addr = 4'd1; bus.load_data = 16'hFFFF;
        bus.start = 1'b1; bus.prog_len = 5'd1;
        tick(1);
        bus.load_en = 1'b0;
        bus.start = 1'b0;
        check("t6_instr_stable", {16'd0, bus.instr_out}, 32'h6002);
        check("t6_still_busy", {31'd0, bus.busy}, 1);
        check("t6_cnt_kept", {16'd0, bus.instr_count}, 1);
        wait_pd("t6_finish", 40);
        check("t6_r0", {16'd0, r0}, 7);
        check("t6_cnt3", {16'd0, bus.instr_count}, 3);
        tick(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end
endmodule
